// File: rtl/mem_access_unit_if.sv
// Load/store request, response and data-memory command bundle for mem_access_unit.
// Handshake: a request transfers on a posedge where req_valid && req_ready; resp_valid is a one-cycle pulse with no backpressure.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [1:0]  mem_size_out;
  logic        mem_we_out;
  logic        mem_re_out;
  logic [31:0] mem_data_in;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_signed, mem_data_in,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_addr_out, mem_data_out, mem_size_out, mem_we_out, mem_re_out
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_signed, mem_data_in,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_addr_out, mem_data_out, mem_size_out, mem_we_out, mem_re_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for the byte-laned data memory: range check, aligned access, sign/zero extension.
// Define MEM_ACCESS_SPLIT_EN to decompose misaligned half/word accesses into byte accesses.
module mem_access_unit #(
  parameter logic [15:0] MEM_ADDR = 16'h1000
) (
  input  logic             clock,
  input  logic             reset,
  mem_access_unit_if.slave bus,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nx;
  logic        we_q, signed_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] last_addr, cur_addr, raw, ext_val;
  logic        misaligned, req_err, last_acc;
`ifdef MEM_ACCESS_SPLIT_EN
  logic        split_q;
  logic [1:0]  idx_q;
  logic [31:0] asm_q, asm_nx, lane_sh, wbyte_sh;
`endif

  // Request decode: the last byte of the access must also fall inside the region.
  always_comb begin
    case (bus.req_size)
      2'd0:    last_addr = bus.req_addr;
      2'd1:    last_addr = bus.req_addr + 32'd1;
      default: last_addr = bus.req_addr + 32'd3;
    endcase
    misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'd3) && (bus.req_addr[1:0] != 2'd0));
    req_err = (bus.req_size == 2'd2) || (bus.req_addr[31:16] != MEM_ADDR) ||
              (last_addr[31:16] != MEM_ADDR);
`ifndef MEM_ACCESS_SPLIT_EN
    req_err = req_err || misaligned;
`endif
  end

  always_comb begin
`ifdef MEM_ACCESS_SPLIT_EN
    cur_addr = addr_q + {30'd0, idx_q};
    lane_sh  = bus.mem_data_in >> {cur_addr[1:0], 3'b000};
    asm_nx   = asm_q | ({24'd0, lane_sh[7:0]} << {idx_q, 3'b000});
    wbyte_sh = wdata_q >> {idx_q, 3'b000};
    last_acc = !split_q || (idx_q == ((size_q == 2'd1) ? 2'd1 : 2'd3));
    raw      = split_q ? asm_nx : (bus.mem_data_in >> {addr_q[1:0], 3'b000});
`else
    cur_addr = addr_q;
    last_acc = 1'b1;
    raw      = bus.mem_data_in >> {addr_q[1:0], 3'b000};
`endif
    case (size_q)
      2'd0:    ext_val = signed_q ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      2'd1:    ext_val = signed_q ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: ext_val = raw;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = req_err ? RESP : ACCESS;
      ACCESS:  if (last_acc) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
`ifdef MEM_ACCESS_SPLIT_EN
      split_q  <= 1'b0;
      idx_q    <= 2'd0;
      asm_q    <= 32'd0;
`endif
    end else begin
      state <= state_nx;
      if ((state == IDLE) && bus.req_valid) begin
        we_q     <= bus.req_we;
        signed_q <= bus.req_signed;
        err_q    <= req_err;
        size_q   <= bus.req_size;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rdata_q  <= 32'd0;
`ifdef MEM_ACCESS_SPLIT_EN
        split_q  <= misaligned;
        idx_q    <= 2'd0;
        asm_q    <= 32'd0;
`endif
      end
      if (state == ACCESS) begin
`ifdef MEM_ACCESS_SPLIT_EN
        if (split_q) begin
          asm_q <= asm_nx;
          idx_q <= idx_q + 2'd1;
        end
`endif
        if (last_acc) rdata_q <= we_q ? 32'd0 : ext_val;
      end
    end
  end

  always_comb begin
    bus.req_ready    = (state == IDLE);
    bus.resp_valid   = (state == RESP);
    bus.resp_rdata   = (state == RESP) ? rdata_q : 32'd0;
    bus.resp_error   = (state == RESP) && err_q;
    bus.mem_addr_out = 32'd0;
    bus.mem_data_out = 32'd0;
    bus.mem_size_out = 2'd3;
    bus.mem_we_out   = 1'b0;
    bus.mem_re_out   = 1'b0;
    state_dbg        = state;
    if (state == ACCESS) begin
      bus.mem_addr_out = cur_addr;
      bus.mem_data_out = wdata_q;
      bus.mem_size_out = size_q;
      bus.mem_we_out   = we_q;
      bus.mem_re_out   = !we_q;
`ifdef MEM_ACCESS_SPLIT_EN
      if (split_q) begin
        bus.mem_size_out = 2'd0;
        bus.mem_data_out = {24'd0, wbyte_sh[7:0]};
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan steps plus random requests
// against a byte-array reference memory and a per-request command scoreboard.
module tb_mem_access_unit;
  localparam logic [15:0] MEM_ADDR = 16'h1000;
`ifdef MEM_ACCESS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] state_dbg;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_ADDR(MEM_ADDR)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  dut_mem [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [33:0] exp_q[$];
  logic [31:0] wr_sh;
  logic [11:0] wr_idx;
  int          wr_n;

  // Byte-laned memory: right-justified write data, asynchronous word read.
  assign bus.mem_data_in = {dut_mem[{bus.mem_addr_out[11:2], 2'd3}], dut_mem[{bus.mem_addr_out[11:2], 2'd2}],
                            dut_mem[{bus.mem_addr_out[11:2], 2'd1}], dut_mem[{bus.mem_addr_out[11:2], 2'd0}]};

  always @(posedge clock) begin
    if (bus.mem_we_out) begin
      wr_n  = (bus.mem_size_out == 2'd0) ? 1 : (bus.mem_size_out == 2'd1) ? 2 : 4;
      wr_sh = bus.mem_data_out;
      for (int k = 0; k < wr_n; k++) begin
        wr_idx = bus.mem_addr_out[11:0] + 12'(k);
        dut_mem[wr_idx] = wr_sh[7:0];
        wr_sh = wr_sh >> 8;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_idle();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 50 && !bus.req_ready; c++) @(negedge clock);
    check("ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_idle_cmd(input string tag);
    check(tag, {bus.mem_we_out, bus.mem_re_out, 28'd0, bus.mem_size_out}, {2'b00, 28'd0, 2'd3});
    check({tag, "_addr_data"}, bus.mem_addr_out | bus.mem_data_out, 32'd0);
  endtask

  // Issue one request from a negedge and follow it to its response.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sgn, output logic [31:0] rdata_seen);
    int          n, exp_lat, lat, we_cnt, re_cnt;
    bit          mis, err, seen;
    logic [31:0] last, a, exp_rdata, got_w, exp_w, wsh;
    logic [33:0] e;
    n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    last = addr + 32'(n - 1);
    mis  = (addr & 32'(n - 1)) != 32'd0;
    err  = (size == 2'd2) || (addr[31:16] != MEM_ADDR) || (last[31:16] != MEM_ADDR) || (mis && !SPLIT);
    exp_lat = err ? 1 : (mis ? n + 1 : 2);
    exp_q.delete();
    if (!err) begin
      if (mis) for (int i = 0; i < n; i++) begin a = addr + 32'(i); exp_q.push_back({a, 2'd0}); end
      else exp_q.push_back({addr, size});
    end
    exp_rdata = 32'd0;
    if (!err && !we) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        exp_rdata = exp_rdata | ({24'd0, ref_mem[a[11:0]]} << (8 * i));
      end
      if (n == 1) exp_rdata = sgn ? {{24{exp_rdata[7]}}, exp_rdata[7:0]} : {24'd0, exp_rdata[7:0]};
      if (n == 2) exp_rdata = sgn ? {{16{exp_rdata[15]}}, exp_rdata[15:0]} : {16'd0, exp_rdata[15:0]};
    end

    wait_ready();
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_size = size; bus.req_signed = sgn;
    seen = 0; lat = 0; we_cnt = 0; re_cnt = 0; rdata_seen = 32'd0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clock);
      if (bus.mem_we_out || bus.mem_re_out) begin
        if (bus.mem_we_out) we_cnt++;
        if (bus.mem_re_out) re_cnt++;
        if (exp_q.size() == 0) check("extra_cmd", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("cmd_addr", bus.mem_addr_out, e[33:2]);
          check("cmd_size", 32'(bus.mem_size_out), 32'(e[1:0]));
        end
      end
      if (bus.resp_valid) begin
        seen = 1; lat = c; rdata_seen = bus.resp_rdata;
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_error", 32'(bus.resp_error), 32'(err));
        check("resp_rdata", bus.resp_rdata, exp_rdata);
        check_idle_cmd("resp_cmd_idle");
      end
      // Busy-time input noise must not disturb the captured request.
      bus.req_valid = seen ? 1'b0 : 1'($urandom_range(0, 1));
      bus.req_we = 1'($urandom); bus.req_addr = $urandom; bus.req_wdata = $urandom;
      bus.req_size = 2'($urandom); bus.req_signed = 1'($urandom);
    end
    if (!seen) $error("FAIL resp_timeout: observed no resp_valid (state_dbg %0d) expected pulse", state_dbg);
    if (!seen) n_checks++;
    check("we_cycles", 32'(we_cnt), (!err && we) ? 32'(exp_q.size() + (mis ? n : 1)) : 32'd0);
    check("re_cycles", 32'(re_cnt), (!err && !we) ? 32'(mis ? n : 1) : 32'd0);
    check("cmds_left", 32'(exp_q.size()), 32'd0);
    drive_idle();
    if (!err && we) begin
      wsh = wdata; got_w = 32'd0; exp_w = 32'd0;
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        ref_mem[a[11:0]] = wsh[7:0];
        wsh = wsh >> 8;
        got_w = got_w | ({24'd0, dut_mem[a[11:0]]} << (8 * i));
        exp_w = exp_w | ({24'd0, ref_mem[a[11:0]]} << (8 * i));
      end
      check("store_mem", got_w, exp_w);
    end
  endtask

  initial begin
    logic [31:0] r, r10, r14, a, got_w, exp_w, wsh, kaddr, kdata, raddr;
    logic [7:0]  b;
    int          kill_cyc, committed, rv_seen;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      dut_mem[i] = b;
      ref_mem[i] = b;
    end
    drive_idle();
    repeat (2) @(negedge clock);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp", {bus.resp_valid, bus.resp_error, 30'd0}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check_idle_cmd("rst_cmd");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    do_req(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 2'd3, 1'b0, r);
    do_req(1'b0, 32'h1000_0010, 32'd0, 2'd3, 1'b0, r);
    check("word_load", r, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h1000_0010, 32'h80FF_1234, 2'd3, 1'b0, r);
    do_req(1'b0, 32'h1000_0013, 32'd0, 2'd0, 1'b1, r);
    check("sbyte_load", r, 32'hFFFF_FF80);
    do_req(1'b0, 32'h1000_0013, 32'd0, 2'd0, 1'b0, r);
    check("ubyte_load", r, 32'h0000_0080);
    do_req(1'b0, 32'h1000_0012, 32'd0, 2'd1, 1'b1, r);
    check("shalf_load", r, 32'hFFFF_80FF);

    do_req(1'b1, 32'h1000_0011, 32'h4433_2211, 2'd3, 1'b0, r);
    do_req(1'b0, 32'h1000_0010, 32'd0, 2'd3, 1'b0, r10);
    do_req(1'b0, 32'h1000_0014, 32'd0, 2'd3, 1'b0, r14);
`ifdef MEM_ACCESS_SPLIT_EN
    check("split_lo", r10 >> 8, 32'h0033_2211);
    check("split_hi", {24'd0, r14[7:0]}, 32'h0000_0044);
`endif
    do_req(1'b0, 32'h1000_0001, 32'd0, 2'd1, 1'b1, r);
    do_req(1'b1, 32'h2000_0000, 32'h1234_5678, 2'd0, 1'b0, r);
    do_req(1'b1, 32'h1000_FFFE, 32'h1234_5678, 2'd3, 1'b0, r);
    do_req(1'b0, 32'h1000_FFFF, 32'd0, 2'd1, 1'b0, r);
    do_req(1'b0, 32'h1000_0000, 32'd0, 2'd2, 1'b0, r);
    do_req(1'b1, 32'h1000_FFFC, 32'hCAFE_F00D, 2'd3, 1'b0, r);
    do_req(1'b0, 32'h1000_FFFC, 32'd0, 2'd3, 1'b0, r);
    check("top_word", r, 32'hCAFE_F00D);

    // Reset in the middle of a store: only already-committed bytes may change.
`ifdef MEM_ACCESS_SPLIT_EN
    kaddr = 32'h1000_0021; kill_cyc = 2; committed = 1;
`else
    kaddr = 32'h1000_0020; kill_cyc = 1; committed = 0;
`endif
    kdata = 32'hA5C3_E781;
    wait_ready();
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = kaddr;
    bus.req_wdata = kdata; bus.req_size = 2'd3; bus.req_signed = 1'b0;
    for (int k = 0; k < kill_cyc; k++) begin
      @(negedge clock);
      drive_idle();
    end
    reset = 1'b0;
    #1;
    check("kill_req_ready", 32'(bus.req_ready), 32'd1);
    check("kill_resp", {bus.resp_valid, bus.resp_error, 30'd0}, 32'd0);
    check("kill_rdata", bus.resp_rdata, 32'd0);
    check_idle_cmd("kill_cmd");
    rv_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bus.resp_valid || bus.mem_we_out) rv_seen++;
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bus.resp_valid || bus.mem_we_out) rv_seen++;
    end
    check("kill_no_resp", 32'(rv_seen), 32'd0);
    check("kill_ready_after", 32'(bus.req_ready), 32'd1);
    wsh = kdata; got_w = 32'd0; exp_w = 32'd0;
    for (int i = 0; i < 4; i++) begin
      a = kaddr + 32'(i);
      if (i < committed) ref_mem[a[11:0]] = wsh[7:0];
      wsh = wsh >> 8;
      got_w = got_w | ({24'd0, dut_mem[a[11:0]]} << (8 * i));
      exp_w = exp_w | ({24'd0, ref_mem[a[11:0]]} << (8 * i));
    end
    check("kill_mem", got_w, exp_w);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 15))
        0:       raddr = $urandom;
        1, 2:    raddr = 32'h1000_FFF8 + 32'($urandom_range(0, 7));
        default: raddr = 32'h1000_0000 + 32'($urandom_range(0, 31));
      endcase
      do_req(1'($urandom), raddr, $urandom, 2'($urandom), 1'($urandom), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store unit that drives the 4 KB byte-laned data memory port (`addr/data/size/we/re`) on behalf of the pipeline. Accepts one load or store request at a time through a valid/ready handshake, checks the address against the memory region, and issues aligned accesses. Misaligned accesses are decomposed into per-byte accesses, because the memory does not implement its unaligned size code. Load data is lane-extracted and sign- or zero-extended. The unit sits between the execute stage and the data memory.

## Interface
Parameters:
- `MEM_ADDR`, 16'h1000, required value of `addr[31:16]` for an access to be in range.

Ports:
- `clock` in 1: single clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, little-endian, right-justified.
- `req_size` in 2: 0 = byte, 1 = half, 3 = word; 2 is reserved and returns an error.
- `req_signed` in 1: sign-extend load result.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_error` out 1: qualifies `resp_valid`; out-of-range, reserved size, or unsupported misaligned access.
- `mem_addr_out` out 32; `mem_data_out` out 32; `mem_size_out` out 2; `mem_we_out` out 1; `mem_re_out` out 1: memory command.
- `mem_data_in` in 32: asynchronous read data from memory.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, capture all request fields.
  - Go to RESP with error if any of: `req_size`==2; `addr[31:16]`!=`MEM_ADDR`; last byte `addr+N-1` has `[31:16]`!=`MEM_ADDR`.
  - Otherwise go to ACCESS with byte index i=0.
- **Aligned access:** half at offset 0/2, word at offset 0, or any byte.
  - One ACCESS cycle with `mem_size_out`=`req_size`, `mem_addr_out`=`addr`.
  - `mem_data_out`=`req_wdata`.
- **Misaligned access:** half at offset 1/3, word at offset 1/2/3.
  - N byte accesses (N=2 or 4), i=0..N-1, one per cycle.
  - `mem_addr_out`=`addr+i` (32-bit add), `mem_size_out`=0.
  - `mem_data_out[7:0]`=`req_wdata` byte i.
- **Store:** `mem_we_out`=1 in every ACCESS cycle.
- **Load:**
  - `mem_re_out`=1 in every ACCESS cycle.
  - At each ACCESS posedge, assembled byte i ← `mem_data_in` lane `(addr+i)[1:0]`.
  - Aligned half and word loads take lanes from `addr[1:0]` upward.
- **Extension:** byte → bit 7, half → bit 15. Extend with that bit if `req_signed`, else zero-fill. Word loads pass through.
- After the last ACCESS cycle, go to RESP.
- **RESP:**
  - `resp_valid`=1 for one cycle; `resp_rdata`/`resp_error` valid.
  - Return to IDLE.
- **Idle command values:** outside ACCESS, `mem_we_out`=`mem_re_out`=0, `mem_addr_out`=0, `mem_data_out`=0, `mem_size_out`=3.
- **Errored requests:** never assert `mem_we_out` or `mem_re_out`.

## Timing
- **Reset values:** state IDLE; `req_ready`=1; `resp_valid`=0, `resp_rdata`=0, `resp_error`=0; memory command at the idle values.
- **Latency:** acceptance edge → `resp_valid`.
  - Aligned: 2 cycles.
  - Misaligned: N+1 cycles.
  - Error: 1 cycle.
- **Throughput:** one request per latency+1 cycles. `req_ready` is low in ACCESS and RESP.
- **Reset mid-operation:** returns immediately to IDLE. Any `resp_valid` is suppressed. Bytes of a split store already committed stay written.
- **Input stability:** request inputs are ignored while `req_ready`=0. Captured values are never affected by later input changes.
- **Read-data sampling:** `mem_data_in` is sampled only on ACCESS-cycle posedges of loads.

## Configuration
- `MEM_ACCESS_SPLIT_EN` defined: misaligned accesses are decomposed as above.
- Not defined:
  - Misaligned half/word requests go straight to RESP with `resp_error`=1, `resp_rdata`=0, 1-cycle latency.
  - No memory command is issued.
  - The byte counter and assembly register are not built.

## Test plan
- Aligned word store 0x10000010 ← 0xDEADBEEF, then word load of the same address. Required: one `mem_we_out` cycle with size 3; `resp_rdata`=0xDEADBEEF 2 cycles after acceptance.
- Signed byte load at 0x10000013 with memory word 0x80FF1234. Required: `resp_rdata`=0xFFFFFF80. Same load unsigned: 0x00000080.
- Split enabled: misaligned word store 0x10000011 ← 0x44332211. Required: four byte writes at 0x…11/12/13/14 with data 0x11/0x22/0x33/0x44; `resp_valid` 5 cycles after acceptance. Follow-up word loads at 0x…10/0x…14 show 0x332211xx and 0xxxxxxx44.
- Split disabled: half load at 0x10000001. Required: `resp_error`=1 after 1 cycle; no `mem_re_out`.
- Out-of-range accesses, store to 0x20000000 and word store at 0x1000FFFE (split enabled). Required: `resp_error`=1; `mem_we_out` never asserted.
- `reset` asserted low during the 2nd byte of a split store. Required: outputs return to reset values asynchronously; `resp_valid` stays 0; `req_ready`=1 after release.
